muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Iterative multi-cycle multiply/divide unit and controller for the EX stage of the 5-stage RISC-V pipeline.
//   Accepts one M-extension op (unsigned subset), runs a radix-2 shift-add / restoring-divide loop,
//   and holds the pipeline via stall until the result is ready. Sits beside the single-cycle ALU;
//   the EX-stage mux selects result when done is high.
// PARAMETERS
//   WIDTH   32   operand/result width; iteration count equals WIDTH
// PORTS
//   clk     in   1      system clock, all state updates on rising edge
//   rst     in   1      synchronous, active-high reset
//   start   in   1      request; sampled only in IDLE
//   op      in   2      0=MUL (low word), 1=MULHU (high word), 2=DIVU (quotient), 3=REMU (remainder)
//   in1     in   WIDTH  multiplicand / dividend, captured on accepted start
//   in2     in   WIDTH  multiplier / divisor, captured on accepted start
//   flush   in   1      abort current op (branch mispredict / jump)
//   stall   out  1      hold IF/ID/EX pipeline registers
//   busy    out  1      operation in progress (RUN or DONE)
//   done    out  1      one-cycle pulse: result valid
//   result  out  WIDTH  selected result; held until the next accepted start
// BEHAVIOUR
//   Reset: state=IDLE, stall=0, busy=0, done=0, result=0, count=0, internal acc/operand regs=0.
//   FSM states: IDLE, RUN, DONE.
//   - IDLE: start=1 & flush=0 -> capture in1/in2/op, count=0, go RUN. start ignored if flush=1.
//   - RUN:  one iteration per cycle; count increments; count==WIDTH-1 -> DONE.
//   - DONE: done=1, result valid, go IDLE next cycle.
//   MUL/MULHU: 2*WIDTH-bit accumulator {hi,lo}, shift-add on LSB of multiplier; all unsigned.
//     MUL returns low WIDTH bits, MULHU returns high WIDTH bits.
//   DIVU/REMU: restoring division; remainder register WIDTH+1 bits, subtract-and-test each step.
//   Divide by zero (in2==0 on accepted start): skip RUN and go IDLE->DONE directly.
//     quotient = all ones, remainder = in1. done occurs 1 cycle after start.
//   Latency: start accepted at edge N -> done=1 during cycle N+WIDTH+1 (33 for WIDTH=32).
//   stall = (state==IDLE & start & ~flush) | (state==RUN).
//     stall is low in DONE, so the pipeline advances on the cycle result is consumed.
//   start while busy: ignored; no queueing. The pipeline guarantees start only rises while stall=0.
//   flush in RUN or DONE: return to IDLE next edge. done is suppressed (flush in DONE forces done=0)
//     and result is unchanged. flush has priority over start.
//   rst mid-operation: behaves exactly as power-on reset; no done pulse.
//   Arithmetic is modulo 2^WIDTH; no overflow flag.
//   Operand registers are not re-sampled during RUN; in1/in2 may change freely.
// TESTING
//   1. rst 2 cycles, then start op=0 in1=6 in2=7 -> stall high 33 cycles, done at +33, result=42.
//   2. op=1 in1=in2=0xFFFFFFFF -> result=0xFFFFFFFE at +33. Repeat with op=0 -> result=0x00000001.
//   3. op=2 in1=100 in2=7 -> result=14. op=3, same operands -> result=2. Both done at +33.
//   4. op=2 in1=0x1234 in2=0 -> done at +1, result=0xFFFFFFFF. op=3 in2=0 -> result=0x1234.
//   5. start op=0 in1=5 in2=5; flush at cycle +10 -> IDLE next edge, no done, result still 0.
//      Restart in the same cycle -> accepted normally.
//   6. rst asserted at cycle +20 of DIVU -> stall/busy/done/result=0 next edge.
//      start pulses during RUN are ignored; result matches the first op only.

Source files
------------

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the EX stage and the multiply/divide sequencer
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  modport master (output start, op, in1, in2, flush, input stall, busy, done, result);
  modport slave (input start, op, in1, in2, flush, output stall, busy, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: radix-2 iterative unsigned MUL/MULHU/DIVU/REMU unit with pipeline stall control
module muldiv_sequencer #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state, op_r;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] hi, lo, b, held, res, hi_n, lo_n;
  logic [WIDTH:0] sum, sh, diff;
  logic accept, ge;
  // One iteration: hi/lo act as the product {hi,lo} for multiply and as remainder/quotient for divide
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    sh = {hi, lo[WIDTH-1]};
    diff = sh - {1'b0, b};
    ge = ~diff[WIDTH];
    hi_n = op_r[1] ? (ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0]) : sum[WIDTH:1];
    lo_n = op_r[1] ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
    res = op_r[0] ? hi : lo;
    accept = (state == IDLE) & bus.start & ~bus.flush;
  end
  assign bus.stall = accept | (state == RUN);
  assign bus.busy = state != IDLE;
  assign bus.done = (state == DONE) & ~bus.flush;
  assign bus.result = bus.done ? res : held;
  // Control FSM and datapath registers; divide-by-zero preloads the architectural result and skips RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_r <= '0;
      count <= '0;
      hi <= '0;
      lo <= '0;
      b <= '0;
      held <= '0;
    end else if (state != IDLE && bus.flush) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (accept) begin
        op_r <= bus.op;
        b <= bus.op[1] ? bus.in2 : bus.in1;
        count <= '0;
        hi <= (bus.op[1] && bus.in2 == '0) ? bus.in1 : '0;
        lo <= (bus.op[1] && bus.in2 == '0) ? '1 : (bus.op[1] ? bus.in1 : bus.in2);
        state <= (bus.op[1] && bus.in2 == '0) ? DONE : RUN;
      end
    end else if (state == RUN) begin
      hi <= hi_n;
      lo <= lo_n;
      count <= count + 1'b1;
      if (count == CW'(WIDTH - 1)) state <= DONE;
    end else begin
      if (state == DONE) held <= res;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed scoreboard bench for the multiply/divide sequencer
module tb_muldiv_sequencer;
  logic clk = 0, rst = 1;
  int n_chk = 0, n_fail = 0, dn = 0;
  logic [31:0] last = 0;
  logic [31:0] q[$];
  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_sequencer #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.done) dn++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, d};
    case (o)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: return d == 0 ? 32'hFFFFFFFF : a / d;
      default: return d == 0 ? a : a % d;
    endcase
  endfunction
  task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d, input int lat, input bit fl_done, input bit noise);
    int cyc, st;
    bit seen;
    logic [31:0] exp;
    bus.start = 1; bus.op = o; bus.in1 = a; bus.in2 = d;
    q.push_back(model(o, a, d));
    @(negedge clk);
    chk("stall_on_start", {31'b0, bus.stall}, 1);
    st = 1;
    @(posedge clk); #1;
    bus.start = noise; bus.op = 2'($urandom); bus.in1 = $urandom; bus.in2 = $urandom;
    cyc = 0; seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.done) seen = 1; else if (bus.stall) st++;
    end
    bus.start = 0;
    exp = q.pop_front();
    chk("done_seen", {31'b0, seen}, 1);
    chk("latency", cyc, lat);
    chk("stall_cycles", st, lat);
    if (seen) begin
      chk("stall_low_in_done", {31'b0, bus.stall}, 0);
      if (fl_done) begin
        bus.flush = 1; #1;
        chk("done_killed_by_flush", {31'b0, bus.done}, 0);
        chk("result_kept_on_flush", bus.result, last);
      end else begin
        chk("result", bus.result, exp);
        last = exp;
      end
    end
    @(posedge clk); #1;
    bus.flush = 0;
    chk("idle_after_done", {31'b0, bus.busy}, 0);
    chk("result_held", bus.result, last);
  endtask
  initial begin
    int d0;
    bus.start = 0; bus.op = 0; bus.in1 = 0; bus.in2 = 0; bus.flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, bus.stall}, 0);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_done", {31'b0, bus.done}, 0);
    chk("rst_result", bus.result, 0);
    rst = 0;
    go(0, 6, 7, 33, 0, 0);
    go(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0, 0);
    go(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0, 0);
    go(2, 100, 7, 33, 0, 0);
    go(3, 100, 7, 33, 0, 0);
    go(2, 32'h1234, 0, 1, 0, 0);
    go(3, 32'h1234, 0, 1, 0, 0);
    go(1, 32'h89ABCDEF, 32'h12345678, 33, 0, 0);
    bus.start = 1; bus.op = 0; bus.in1 = 5; bus.in2 = 5;
    @(posedge clk); #1;
    bus.start = 0;
    d0 = dn;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1;
    @(negedge clk);
    chk("flush_run_done", {31'b0, bus.done}, 0);
    chk("flush_run_stall", {31'b0, bus.stall}, 1);
    @(posedge clk); #1;
    bus.flush = 0;
    chk("flush_run_idle", {31'b0, bus.busy}, 0);
    chk("flush_run_stall_low", {31'b0, bus.stall}, 0);
    chk("flush_run_result", bus.result, last);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_run_no_done", dn, d0);
    go(0, 5, 5, 33, 0, 0);
    go(2, 100, 7, 33, 1, 0);
    bus.start = 1; bus.op = 2; bus.in1 = 32'hDEADBEEF; bus.in2 = 3;
    @(posedge clk); #1;
    bus.start = 0;
    d0 = dn;
    repeat (19) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_stall", {31'b0, bus.stall}, 0);
    chk("midrst_busy", {31'b0, bus.busy}, 0);
    chk("midrst_done", {31'b0, bus.done}, 0);
    chk("midrst_result", bus.result, 0);
    last = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_done", dn, d0);
    go(2, 1000, 10, 33, 0, 1);
    go(3, 32'hFFFFFFFF, 32'h10, 33, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
